// File: rtl/rv32_pkg.sv
// Shared RV32 ALU definitions: ALU control encodings, alu_op classes and funct3 values.
package rv32_pkg;

    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned FUNCT3_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [FUNCT3_W-1:0] F3_ADDSUB = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_OR     = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from alu_op/funct3/funct7[5]; unmapped combinations
// produce the ILLEGAL encoding, which is the only source of the illegal flag.
module alu_ctrl_dec
    import rv32_pkg::*;
(
    input  logic [ALUOP_W-1:0]  alu_op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7_5,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                illegal
);

    always_comb begin
        ctrl = ALU_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct3 == F3_ADDSUB)   ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                else if (funct3 == F3_AND) ctrl = ALU_AND;
                else if (funct3 == F3_OR)  ctrl = ALU_OR;
            end
            ALUOP_ITYPE: begin
                // funct7[5] carries immediate bits here, so it must not select SUB
                if (funct3 == F3_ADDSUB)   ctrl = ALU_ADD;
                else if (funct3 == F3_AND) ctrl = ALU_AND;
                else if (funct3 == F3_OR)  ctrl = ALU_OR;
            end
            default: ctrl = ALU_ILLEGAL;
        endcase
    end

    assign illegal = (ctrl == ALU_ILLEGAL);

endmodule

// File: rtl/alu_issue.sv
// One-entry ALU issue register: resolves forwarded operands at accept, decodes ALU
// control and holds the result behind a valid/ready handshake with zero-bubble reload.
module alu_issue
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic [REGW-1:0]     rs1_addr,
    input  logic [REGW-1:0]     rs2_addr,
    input  logic [REGW-1:0]     rd_addr,
    input  logic [XLEN-1:0]     imm,
    input  logic                alu_src,
    input  logic [ALUOP_W-1:0]  alu_op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7_5,
    input  logic                fwd_mem_we,
    input  logic [REGW-1:0]     fwd_mem_rd,
    input  logic [XLEN-1:0]     fwd_mem_data,
    input  logic                fwd_wb_we,
    input  logic [REGW-1:0]     fwd_wb_rd,
    input  logic [XLEN-1:0]     fwd_wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     a,
    output logic [XLEN-1:0]     b,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [REGW-1:0]     out_rd,
    output logic                illegal
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e              r_state;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [REGW-1:0]     r_rd;
    logic                r_illegal;

    logic                w_accept;
    logic [XLEN-1:0]     w_rs1_val;
    logic [XLEN-1:0]     w_rs2_val;
    logic [XLEN-1:0]     w_b_val;
    logic [CTRL_W-1:0]   w_dec_ctrl;
    logic                w_dec_illegal;

    // Flush forces ready so decode is never stalled against a discarded entry
    assign in_ready = flush | (r_state == ST_EMPTY) | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    // Forwarding: EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded
    always_comb begin
        w_rs1_val = rs1_data;
        if (rs1_addr != '0) begin
            if (fwd_mem_we && (fwd_mem_rd == rs1_addr))     w_rs1_val = fwd_mem_data;
            else if (fwd_wb_we && (fwd_wb_rd == rs1_addr))  w_rs1_val = fwd_wb_data;
        end
    end

    always_comb begin
        w_rs2_val = rs2_data;
        if (rs2_addr != '0) begin
            if (fwd_mem_we && (fwd_mem_rd == rs2_addr))     w_rs2_val = fwd_mem_data;
            else if (fwd_wb_we && (fwd_wb_rd == rs2_addr))  w_rs2_val = fwd_wb_data;
        end
    end

    assign w_b_val = alu_src ? imm : w_rs2_val;

    alu_ctrl_dec u_dec (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .ctrl     (w_dec_ctrl),
        .illegal  (w_dec_illegal)
    );

    // State register and payload; reset beats flush, flush beats accept/drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_a       <= '0;
            r_b       <= '0;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_EMPTY;
        end else begin
            if (w_accept) begin
                r_a       <= w_rs1_val;
                r_b       <= w_b_val;
                r_ctrl    <= w_dec_ctrl;
                r_rd      <= rd_addr;
                r_illegal <= w_dec_illegal;
            end
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (!w_accept && out_ready) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign a         = r_a;
    assign b         = r_b;
    assign ctrl      = r_ctrl;
    assign out_rd    = r_rd;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed plus randomized bench for alu_issue; an independent model predicts each
// accepted instruction into a scoreboard that is compared while the stage holds it.
module tb_alu_issue;
    import rv32_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [4:0]  out_rd;
    logic        illegal;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    bit   m_full;
    int   vectors;
    int   miscompares;

    alu_issue #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .imm(imm), .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3),
        .funct7_5(funct7_5), .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_data(fwd_wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .ctrl(ctrl), .out_rd(out_rd), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_opnd(input logic [4:0] addr, input logic [31:0] rdata);
        if (addr == 5'd0) return rdata;
        if (fwd_mem_we && fwd_mem_rd == addr) return fwd_mem_data;
        if (fwd_wb_we && fwd_wb_rd == addr) return fwd_wb_data;
        return rdata;
    endfunction

    // Returns {illegal, ctrl}
    function automatic logic [4:0] m_dec(input logic [1:0] op, input logic [2:0] f3, input logic f7);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (f3 == 3'b000) return (op == 2'b10 && f7) ? 5'b0_0110 : 5'b0_0010;
        if (f3 == 3'b111) return 5'b0_0000;
        if (f3 == 3'b110) return 5'b0_0001;
        return 5'b1_1111;
    endfunction

    task automatic set_instr(input logic [31:0] r1d, input logic [31:0] r2d,
                             input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rd,
                             input logic [31:0] im, input logic src, input logic [1:0] op,
                             input logic [2:0] f3, input logic f7);
        in_valid = 1'b1;
        rs1_data = r1d; rs2_data = r2d; rs1_addr = r1a; rs2_addr = r2a; rd_addr = rd;
        imm = im; alu_src = src; alu_op = op; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdat,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat);
        fwd_mem_we = mwe; fwd_mem_rd = mrd; fwd_mem_data = mdat;
        fwd_wb_we = wwe; fwd_wb_rd = wrd; fwd_wb_data = wdat;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_a"}, a, 32'd0);
        check({tag, "_b"}, b, 32'd0);
        check({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        check({tag, "_rd"}, 32'(out_rd), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    // One clock: predict accept/drain from current inputs, advance, compare outputs
    task automatic cycle();
        exp_t e;
        bit acc, drn, exp_rdy;
        logic [4:0] d;
        #1;
        exp_rdy = flush || !m_full || out_ready;
        if (!rst) check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = !rst && !flush && in_valid && exp_rdy;
        drn = m_full && out_ready;
        e.a = m_opnd(rs1_addr, rs1_data);
        e.b = alu_src ? imm : m_opnd(rs2_addr, rs2_data);
        d = m_dec(alu_op, funct3, funct7_5);
        e.ill = d[4];
        e.ctrl = d[3:0];
        e.rd = rd_addr;
        @(posedge clk);
        #1;
        if (rst || flush) begin
            sb.delete();
            m_full = 1'b0;
        end else begin
            if (drn && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(e);
                m_full = 1'b1;
            end else if (drn) begin
                m_full = 1'b0;
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            check("a", a, sb[0].a);
            check("b", b, sb[0].b);
            check("ctrl", 32'(ctrl), 32'(sb[0].ctrl));
            check("out_rd", 32'(out_rd), 32'(sb[0].rd));
            check("illegal", 32'(illegal), 32'(sb[0].ill));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_full = 1'b0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0);
        in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        cycle();
        cycle();
        check_zero("reset");
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // R-type ADD, no forwarding
        set_instr(32'd5, 32'd7, 5'd1, 5'd2, 5'd10, 32'h0, 1'b0, 2'b10, 3'b000, 1'b0);
        cycle();
        check("add_a", a, 32'd5);
        check("add_b", b, 32'd7);
        check("add_ctrl", 32'(ctrl), 32'h2);
        in_valid = 1'b0;
        cycle();

        // Forwarding priority and x0 exclusion, back-to-back
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_instr(32'h11, 32'h22, 5'd3, 5'd4, 5'd5, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0);
        cycle();
        check("fwd_mem_a", a, 32'hAA);
        set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_instr(32'h11, 32'h22, 5'd3, 5'd3, 5'd6, 32'h0, 1'b0, 2'b01, 3'b000, 1'b0);
        cycle();
        check("fwd_wb_a", a, 32'hBB);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        set_instr(32'h33, 32'h44, 5'd0, 5'd0, 5'd7, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0);
        cycle();
        check("x0_a", a, 32'h33);
        check("x0_b", b, 32'h44);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Immediate operand, I-type OR
        set_instr(32'h1, 32'h2, 5'd8, 5'd9, 5'd11, 32'h100, 1'b1, 2'b11, 3'b110, 1'b0);
        cycle();
        check("imm_b", b, 32'h100);

        // Illegal R-type and I-type funct7_5 ignored
        set_instr(32'h1, 32'h2, 5'd8, 5'd9, 5'd12, 32'h0, 1'b0, 2'b10, 3'b001, 1'b0);
        cycle();
        check("ill_ctrl", 32'(ctrl), 32'hF);
        check("ill_flag", 32'(illegal), 32'd1);
        set_instr(32'h1, 32'h2, 5'd8, 5'd9, 5'd13, 32'h5, 1'b1, 2'b11, 3'b000, 1'b1);
        cycle();
        check("itype_f7_ctrl", 32'(ctrl), 32'h2);
        check("itype_f7_ill", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Stall for 3 cycles, then drain and accept on the same edge
        out_ready = 1'b0;
        set_instr(32'hA1, 32'hA2, 5'd1, 5'd2, 5'd14, 32'h0, 1'b0, 2'b10, 3'b111, 1'b0);
        cycle();
        set_instr(32'hB1, 32'hB2, 5'd1, 5'd2, 5'd15, 32'h0, 1'b0, 2'b10, 3'b000, 1'b1);
        repeat (3) cycle();
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_a", a, 32'hA1);
        out_ready = 1'b1;
        cycle();
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_a", a, 32'hB1);
        check("nobubble_ctrl", 32'(ctrl), 32'h6);
        in_valid = 1'b0;
        cycle();

        // Flush while FULL with a presented instruction
        out_ready = 1'b0;
        set_instr(32'hC1, 32'hC2, 5'd1, 5'd2, 5'd16, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0);
        cycle();
        flush = 1'b1;
        set_instr(32'hD1, 32'hD2, 5'd1, 5'd2, 5'd17, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0);
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall
        set_instr(32'hE1, 32'hE2, 5'd1, 5'd2, 5'd18, 32'h0, 1'b0, 2'b10, 3'b110, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_zero("rst_stall");
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Randomized traffic with forwarding hazards and occasional flushes
        for (int i = 0; i < 80; i++) begin
            set_instr($urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom), $urandom, 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
